// File: rtl/pipe_delay_line_pkg.sv
// Shared constants and helpers for the pipe_delay_line block.
//   DefaultWidth / DefaultDepth : default parameter values for the delay line and its interface
//   cnt_width()                 : width of an occupancy counter able to hold 0..depth
package pipe_delay_line_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 4;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_delay_line_if.sv
// Handshake bundle for pipe_delay_line.
//   in_valid / in_ready / in_data    : upstream ready/valid channel
//   out_valid / out_ready / out_data : downstream ready/valid channel
//   occupancy                        : number of valid stages (CNT_W bits)
// modport master : the side that feeds and drains the delay line
// modport slave  : the delay line itself
interface pipe_delay_line_if
  import pipe_delay_line_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) ();

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );

endinterface

// File: rtl/pipe_delay_line_stage.sv
// One stage of the delay line: a valid bit plus a data register.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear of the valid bit (flush)
//   load      : capture nxt_valid (and nxt_data when nxt_valid is set)
//   nxt_valid : incoming valid
//   nxt_data  : incoming data
//   valid     : registered valid
//   data      : registered data (RESET_VAL after reset)
module pipe_delay_line_stage #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             nxt_valid,
  input  logic [WIDTH-1:0] nxt_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else if (clr) begin
      // Data is left stale; only the valid bit matters for an empty slot.
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= nxt_valid;
      if (nxt_valid) begin
        data_q <= nxt_data;
      end
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_delay_line.sv
// DEPTH-stage, WIDTH-bit delay line with per-stage valid bits and ready/valid on both ends.
// Empty stages always accept, so bubbles collapse even while the output is stalled.
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active-high
//   flush : synchronous clear of all stages (wins over input)
//   bus   : pipe_delay_line_if.slave (in_valid/in_ready/in_data, out_valid/out_ready/out_data,
//           occupancy)
module pipe_delay_line
  import pipe_delay_line_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefaultWidth,
  parameter int unsigned      DEPTH     = DefaultDepth,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_delay_line_if.slave     bus
);

  localparam int unsigned     CNT_W   = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] OccMax = CNT_W'(DEPTH);

  logic [DEPTH-1:0] stage_v;
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] acc;
  logic             acc_run;
  logic             in_xfer;
  logic             out_xfer;
  logic [CNT_W-1:0] occ_d, occ_q;

  // acc[i] = !v[i] | acc[i+1], with acc[DEPTH-1] seeded by out_ready. Built as a running OR
  // from the tail so the chain stays a plain combinational ripple.
  always_comb begin
    acc     = '0;
    acc_run = bus.out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      acc_run = acc_run | !stage_v[i];
      acc[i]  = acc_run;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             nxt_valid;
    logic [WIDTH-1:0] nxt_data;

    if (g == 0) begin : g_head
      assign nxt_valid = bus.in_valid;
      assign nxt_data  = bus.in_data;
    end else begin : g_body
      assign nxt_valid = stage_v[g-1];
      assign nxt_data  = stage_d[g-1];
    end

    pipe_delay_line_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .load      (acc[g]),
      .nxt_valid (nxt_valid),
      .nxt_data  (nxt_data),
      .valid     (stage_v[g]),
      .data      (stage_d[g])
    );
  end

  assign bus.in_ready  = acc[0] & !flush;
  assign bus.out_valid = stage_v[DEPTH-1];
  assign bus.out_data  = stage_d[DEPTH-1];

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = stage_v[DEPTH-1] & bus.out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer && occ_q != OccMax) begin
      occ_d = occ_q + 1'b1;
    end else if (!in_xfer && out_xfer && occ_q != '0) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed bench for pipe_delay_line: a DEPTH=4/WIDTH=8 instance for the directed scenarios and a
// DEPTH=1/WIDTH=1 instance driven randomly against a queue model.
module tb_pipe_delay_line;
  import pipe_delay_line_pkg::*;

  localparam logic [7:0] Rv  = 8'h5A;
  localparam logic       Rv1 = 1'b1;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  logic flush1 = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_delay_line_if #(.WIDTH(8), .DEPTH(4)) bus ();
  pipe_delay_line_if #(.WIDTH(1), .DEPTH(1)) bus1 ();

  pipe_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(Rv)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  pipe_delay_line #(.WIDTH(1), .DEPTH(1), .RESET_VAL(Rv1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush1),
    .bus   (bus1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    rst = 1'b0;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++;
      $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    tests++; if (bus.occupancy !== 3'd0) begin fails++;
      $display("FAIL reset_occ got %0d exp 0", bus.occupancy); end
    tests++; if (bus.out_data !== Rv) begin fails++;
      $display("FAIL reset_out_data got %h exp %h", bus.out_data, Rv); end
    tests++; if (bus1.out_data !== Rv1) begin fails++;
      $display("FAIL reset1_out_data got %b exp %b", bus1.out_data, Rv1); end
    // Put four words in flight, then hit reset between clock edges.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h11 + i);
      step();
    end
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin fails++;
      $display("FAIL midrst_pre got v=%b d=%h exp v=1 d=11", bus.out_valid, bus.out_data); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL midrst_out_valid got %b exp 0", bus.out_valid); end
    tests++; if (bus.occupancy !== 3'd0) begin fails++;
      $display("FAIL midrst_occ got %0d exp 0", bus.occupancy); end
    tests++; if (bus.out_data !== Rv) begin fails++;
      $display("FAIL midrst_out_data got %h exp %h", bus.out_data, Rv); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++;
      $display("FAIL midrst_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_streaming();
    int exp_occ;
    step();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h01;
    // c counts edges from the accept edge of word 0x01.
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      exp_occ = ((c + 1 < 16) ? c + 1 : 16) - ((c > 3) ? c - 3 : 0);
      tests++; if (bus.out_valid !== (c >= 3 && c <= 18)) begin fails++;
        $display("FAIL stream_valid c=%0d got %b", c, bus.out_valid); end
      if (c >= 3 && c <= 18) begin
        tests++; if (bus.out_data !== 8'(c - 2)) begin fails++;
          $display("FAIL stream_data c=%0d got %h exp %h", c, bus.out_data, 8'(c - 2)); end
      end
      tests++; if (int'(bus.occupancy) !== exp_occ) begin fails++;
        $display("FAIL stream_occ c=%0d got %0d exp %0d", c, bus.occupancy, exp_occ); end
      tests++; if (int'(bus.occupancy) !== $countones(dut.stage_v)) begin fails++;
        $display("FAIL stream_popcount c=%0d got %0d exp %0d", c, bus.occupancy,
                 $countones(dut.stage_v)); end
      tests++; if (bus.in_ready !== 1'b1) begin fails++;
        $display("FAIL stream_in_ready c=%0d got %b exp 1", c, bus.in_ready); end
      if (c + 1 < 16) bus.in_data = 8'(c + 2);
      else bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h21 + i);
      #1;
      tests++; if (bus.in_ready !== 1'b1) begin fails++;
        $display("FAIL stall_fill_ready i=%0d got %b exp 1", i, bus.in_ready); end
      step();
    end
    bus.in_data = 8'h25;
    for (int k = 0; k < 10; k++) begin
      #1;
      tests++; if (bus.in_ready !== 1'b0) begin fails++;
        $display("FAIL stall_in_ready k=%0d got %b exp 0", k, bus.in_ready); end
      tests++; if (bus.occupancy !== 3'd4) begin fails++;
        $display("FAIL stall_occ k=%0d got %0d exp 4", k, bus.occupancy); end
      tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h21) begin fails++;
        $display("FAIL stall_head k=%0d got v=%b d=%h exp v=1 d=21", k, bus.out_valid,
                 bus.out_data); end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++;
      $display("FAIL stall_release_ready got %b exp 1", bus.in_ready); end
    for (int j = 1; j < 4; j++) begin
      step();
      tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h21 + j)) begin fails++;
        $display("FAIL stall_drain j=%0d got v=%b d=%h exp v=1 d=%h", j, bus.out_valid,
                 bus.out_data, 8'(8'h21 + j)); end
    end
    step();
    tests++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0) begin fails++;
      $display("FAIL stall_empty got v=%b occ=%0d exp v=0 occ=0", bus.out_valid,
               bus.occupancy); end
  endtask

  task automatic test_bubble();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h31;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h32;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++;
      $display("FAIL bubble_ready_second got %b exp 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    tests++; if (dut.stage_v !== 4'b1100) begin fails++;
      $display("FAIL bubble_pack got %b exp 1100", dut.stage_v); end
    tests++; if (bus.occupancy !== 3'd2) begin fails++;
      $display("FAIL bubble_occ got %0d exp 2", bus.occupancy); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++;
      $display("FAIL bubble_in_ready got %b exp 1", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h31) begin fails++;
      $display("FAIL bubble_head got v=%b d=%h exp v=1 d=31", bus.out_valid, bus.out_data); end
    bus.out_ready = 1'b1;
    step();
    tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h32) begin fails++;
      $display("FAIL bubble_second got v=%b d=%h exp v=1 d=32", bus.out_valid, bus.out_data); end
    step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL bubble_empty got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h41 + i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    tests++; if (bus.occupancy !== 3'd3 || bus.out_valid !== 1'b1) begin fails++;
      $display("FAIL flush_pre got occ=%0d v=%b exp occ=3 v=1", bus.occupancy, bus.out_valid); end
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h44;
    #1;
    tests++; if (bus.in_ready !== 1'b0) begin fails++;
      $display("FAIL flush_in_ready got %b exp 0", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h41) begin fails++;
      $display("FAIL flush_deliver got v=%b d=%h exp v=1 d=41", bus.out_valid, bus.out_data); end
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    tests++; if (bus.occupancy !== 3'd0 || bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL flush_clear got occ=%0d v=%b exp occ=0 v=0", bus.occupancy,
               bus.out_valid); end
    tests++; if (dut.stage_v !== 4'b0000) begin fails++;
      $display("FAIL flush_stages got %b exp 0000", dut.stage_v); end
    step();
    step();
    step();
    step();
    tests++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0) begin fails++;
      $display("FAIL flush_no_accept got v=%b occ=%0d exp v=0 occ=0", bus.out_valid,
               bus.occupancy); end
  endtask

  task automatic test_depth1_random();
    logic q[$];
    logic exp_rdy;
    logic in_x;
    logic out_x;
    for (int n = 0; n < 1000; n++) begin
      step();
      bus1.in_valid  = 1'($urandom_range(0, 1));
      bus1.out_ready = 1'($urandom_range(0, 1));
      bus1.in_data   = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = (q.size() == 0) || bus1.out_ready;
      tests++; if (bus1.in_ready !== exp_rdy) begin fails++;
        $display("FAIL d1_in_ready n=%0d got %b exp %b", n, bus1.in_ready, exp_rdy); end
      tests++; if (bus1.out_valid !== (q.size() != 0)) begin fails++;
        $display("FAIL d1_out_valid n=%0d got %b exp %b", n, bus1.out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        tests++; if (bus1.out_data !== q[0]) begin fails++;
          $display("FAIL d1_out_data n=%0d got %b exp %b", n, bus1.out_data, q[0]); end
      end
      tests++; if (int'(bus1.occupancy) !== q.size()) begin fails++;
        $display("FAIL d1_occ n=%0d got %0d exp %0d", n, bus1.occupancy, q.size()); end
      tests++; if (int'(bus1.occupancy) !== $countones(dut1.stage_v)) begin fails++;
        $display("FAIL d1_popcount n=%0d got %0d exp %0d", n, bus1.occupancy,
                 $countones(dut1.stage_v)); end
      out_x = (q.size() != 0) && bus1.out_ready;
      in_x  = bus1.in_valid && exp_rdy;
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(bus1.in_data);
    end
    step();
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 1'b0;
    bus1.out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_stall();
    test_bubble();
    test_flush();
    test_depth1_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
